// File: rtl/clocked_bus_memory.sv
// -----------------------------------------------------------------------------
// clocked_bus_memory
//
// Single-clock bus slave in front of on-chip word storage. A bus master raises
// a request strobe (latch) together with an access direction (RW), an address
// and write data. The block captures the request, waits a programmable number
// of wait states, performs the read or write, and answers with a one-cycle
// ready pulse. An out-of-range address yields an err pulse alongside ready.
// After reset the block can optionally zero the whole array, one word per
// cycle, before it accepts requests.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   latch       in   request strobe, polarity set by POL_LATCH
//   RW          in   access direction, polarity set by POL_RW (internal 1 = read)
//   addIn       in   access address [ADDR_SIZE]
//   DataBusIn   in   write data [DATA_SIZE]
//   DataBusOut  out  registered read data, held until the next read completes
//   ready       out  one-cycle completion pulse
//   busy        out  high whenever the controller is not idle
//   err         out  one-cycle pulse with ready when the address is out of range
// -----------------------------------------------------------------------------
module clocked_bus_memory #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SIZE      = 7,
  parameter int MEMORY_SIZE    = 90,
  parameter int POL_LATCH      = 1,
  parameter int POL_RW         = 1,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 latch,
  input  logic                 RW,
  input  logic [ADDR_SIZE-1:0] addIn,
  input  logic [DATA_SIZE-1:0] DataBusIn,
  output logic [DATA_SIZE-1:0] DataBusOut,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  localparam state_t               RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
  localparam logic                 POL_L       = (POL_LATCH != 0);
  localparam logic                 POL_D       = (POL_RW != 0);
  // The counter is loaded with WAIT_STATES-1 so that ACCESS follows exactly
  // WAIT_STATES cycles spent in WAIT.
  localparam logic [3:0]           WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  // One extra bit so that MEMORY_SIZE == 2^ADDR_SIZE still fits the compare.
  localparam logic [ADDR_SIZE:0]   MEM_LIMIT   = (ADDR_SIZE + 1)'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR   = ADDR_SIZE'(MEMORY_SIZE - 1);

  state_t state;
  state_t next_state;

  logic                 ilatch;
  logic                 irw;
  logic                 latch_q;
  logic                 request;

  logic [3:0]           wait_cnt;
  logic [ADDR_SIZE-1:0] clr_ptr;

  logic [ADDR_SIZE-1:0] hold_addr;
  logic [DATA_SIZE-1:0] hold_data;
  logic                 hold_read;
  logic                 in_range;

  logic                 clear_en;
  logic                 capture_en;
  logic                 access_en;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [DATA_SIZE-1:0] mem_wdata;

  logic [DATA_SIZE-1:0] mem [MEMORY_SIZE];

  // Polarity normalisation: after this point 1 means "strobe active" and
  // "read" regardless of how the bus master drives the pins.
  assign ilatch  = ~(latch ^ POL_L);
  assign irw     = ~(RW ^ POL_D);

  // A request is the inactive-to-active transition of the normalised strobe.
  // latch_q resets to 1 so a strobe held active through reset is not a request.
  assign request = ilatch & ~latch_q;

  assign in_range = ({1'b0, hold_addr} < MEM_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: begin
        if (clr_ptr == LAST_ADDR) begin
          next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (request) begin
          next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = RESET_STATE;
      end
    endcase
  end

  // Per-state control strobes. Requests are only looked at in IDLE, which is
  // what makes strobes during INIT, WAIT and ACCESS disappear.
  always_comb begin
    busy       = 1'b1;
    clear_en   = 1'b0;
    capture_en = 1'b0;
    access_en  = 1'b0;
    case (state)
      ST_INIT: begin
        clear_en = 1'b1;
      end
      ST_IDLE: begin
        busy       = 1'b0;
        capture_en = request;
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      ST_ACCESS: begin
        access_en = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Edge detector, clear pointer, wait counter and request holding registers.
  // The holding registers freeze the request at accept time so later bus
  // activity cannot disturb an access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= 1'b1;
      wait_cnt  <= '0;
      clr_ptr   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_read <= 1'b0;
    end else begin
      latch_q <= ilatch;

      if (clear_en) begin
        clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + ADDR_SIZE'(1);
      end

      if (capture_en) begin
        hold_addr <= addIn;
        hold_data <= DataBusIn;
        hold_read <= irw;
        wait_cnt  <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // The single write port is shared between the post-reset clear sweep and
  // in-range write accesses; the two never overlap in time.
  assign mem_we    = clear_en | (access_en & ~hold_read & in_range);
  assign mem_waddr = clear_en ? clr_ptr : hold_addr;
  assign mem_wdata = clear_en ? '0 : hold_data;

  // Storage has no reset; only the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered response. DataBusOut only changes on a completed read; an
  // out-of-range read returns zero instead of touching the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataBusOut <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
    end else begin
      ready <= access_en;
      err   <= access_en & ~in_range;
      if (access_en && hold_read) begin
        DataBusOut <= in_range ? mem[hold_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_clocked_bus_memory.sv
// -----------------------------------------------------------------------------
// tb_clocked_bus_memory
//
// Scoreboard bench for clocked_bus_memory. Two instances are exercised one
// after another:
//   instance 0: active-high strobe/read, no wait states, clear after reset
//   instance 1: active-low strobe/read, two wait states, no clear
// The stimulus side decides from a transaction-level model whether a strobe
// is accepted (controller free, first edge after reset consumed, clear sweep
// finished), computes the response from a plain word array and queues it.
// An independent monitor pops the queue whenever a ready pulse appears and
// compares timing, data and err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clocked_bus_memory;

  localparam int MEM_WORDS = 90;
  localparam int WS_A      = 0;
  localparam int WS_B      = 2;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      rst_v;
  logic [1:0]      latch_v;
  logic [1:0]      rw_v;
  logic [1:0][6:0] addr_v;
  logic [1:0][7:0] din_v;
  logic [1:0][7:0] dout_v;
  logic [1:0]      ready_v;
  logic [1:0]      busy_v;
  logic [1:0]      err_v;

  int         cur;
  int         n_cmp;
  int         n_fail;
  int         free_at [2];
  logic [7:0] last_read [2];
  logic [7:0] model_mem [2][128];
  exp_t       sb_q [$];

  clocked_bus_memory #(
    .DATA_SIZE(8), .ADDR_SIZE(7), .MEMORY_SIZE(MEM_WORDS), .POL_LATCH(1),
    .POL_RW(1), .WAIT_STATES(WS_A), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_v[0]), .latch(latch_v[0]), .RW(rw_v[0]),
    .addIn(addr_v[0]), .DataBusIn(din_v[0]), .DataBusOut(dout_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );

  clocked_bus_memory #(
    .DATA_SIZE(8), .ADDR_SIZE(7), .MEMORY_SIZE(MEM_WORDS), .POL_LATCH(0),
    .POL_RW(0), .WAIT_STATES(WS_B), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_v[1]), .latch(latch_v[1]), .RW(rw_v[1]),
    .addIn(addr_v[1]), .DataBusIn(din_v[1]), .DataBusOut(dout_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );

  function automatic logic polLatch(input int i);
    return (i == 0);
  endfunction

  function automatic logic polRw(input int i);
    return (i == 0);
  endfunction

  function automatic int waitStates(input int i);
    return (i == 0) ? WS_A : WS_B;
  endfunction

  function automatic bit clears(input int i);
    return (i == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (inst %0d, cycle %0d)",
               name, actual, expected, cur, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued response.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i] && ready_v[i]) begin
        if (i == cur && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checkOutput("ready_latency", 32'(cyc), 32'(e.due));
          checkOutput("read_data", 32'(dout_v[i]), 32'(e.data));
          checkOutput("err_flag", 32'(err_v[i]), 32'(e.err));
        end else begin
          checkOutput("spurious_ready", 32'(ready_v[i]), 32'd0);
        end
      end else if (rst_v[i] && i == cur) begin
        checkOutput("err_without_ready", 32'(err_v[i]), 32'd0);
      end
    end
  end

  // One strobe pulse: active for one cycle, then inactive for one cycle.
  // Called on a falling edge; the accepting rising edge is cyc+1.
  task automatic applyStimulus(input bit rd, input logic [6:0] a, input logic [7:0] d);
    int   t;
    exp_t e;
    t = cyc + 1;
    addr_v[cur]  = a;
    din_v[cur]   = d;
    rw_v[cur]    = rd ? polRw(cur) : ~polRw(cur);
    latch_v[cur] = polLatch(cur);
    if (t >= free_at[cur]) begin
      e.due = t + 1 + waitStates(cur);
      e.err = (int'(a) >= MEM_WORDS);
      if (rd) begin
        last_read[cur] = e.err ? 8'h00 : model_mem[cur][a];
      end else if (!e.err) begin
        model_mem[cur][a] = d;
      end
      e.data = last_read[cur];
      sb_q.push_back(e);
      free_at[cur] = t + 2 + waitStates(cur);
    end
    @(negedge clk);
    latch_v[cur] = ~polLatch(cur);
    addr_v[cur]  = 7'($urandom);
    din_v[cur]   = 8'($urandom);
    rw_v[cur]    = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic resetDut(input int i);
    rst_v[i] = 1'b0;
    @(negedge clk);
    checkOutput("reset_dout", 32'(dout_v[i]), 32'd0);
    checkOutput("reset_ready", 32'(ready_v[i]), 32'd0);
    checkOutput("reset_err", 32'(err_v[i]), 32'd0);
    checkOutput("reset_busy", 32'(busy_v[i]), 32'(clears(i)));
    @(negedge clk);
    sb_q.delete();
    rst_v[i]     = 1'b1;
    last_read[i] = 8'h00;
    if (clears(i)) begin
      for (int k = 0; k < 128; k++) model_mem[i][k] = 8'h00;
      free_at[i] = cyc + MEM_WORDS + 1;
    end else begin
      free_at[i] = cyc + 2;
    end
  endtask

  task automatic measureBusy(input int exp_cycles);
    int n;
    n = 0;
    while (busy_v[cur] && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(n), 32'(exp_cycles));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic randomTraffic(input int count);
    for (int k = 0; k < count; k++) begin
      int         gap;
      bit         rd;
      logic [6:0] a;
      logic [7:0] d;
      gap = $urandom_range(0, 3);
      rd  = ($urandom_range(0, 1) == 1);
      a   = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(90, 127))
                                        : 7'($urandom_range(0, 89));
      d   = 8'($urandom);
      repeat (gap) @(negedge clk);
      applyStimulus(rd, a, d);
    end
  endtask

  initial begin
    logic [7:0] saved;
    n_cmp  = 0;
    n_fail = 0;
    cur    = 0;
    rst_v   = 2'b00;
    latch_v = 2'b00;
    rw_v    = 2'b00;
    addr_v  = '0;
    din_v   = '0;
    for (int i = 0; i < 2; i++) begin
      free_at[i]   = 0;
      last_read[i] = 8'h00;
      for (int k = 0; k < 128; k++) model_mem[i][k] = 8'h00;
    end
    repeat (2) @(negedge clk);

    // Instance 0: clear sweep, basic read, out-of-range, back-to-back.
    $display("[TB] instance 0: active-high, no wait states, clear on reset");
    cur = 0;
    resetDut(0);
    measureBusy(MEM_WORDS);
    applyStimulus(1'b1, 7'd5, 8'h00);
    waitDrain();
    applyStimulus(1'b1, 7'd100, 8'h00);
    applyStimulus(1'b0, 7'd127, 8'hFF);
    applyStimulus(1'b1, 7'd0, 8'h00);
    applyStimulus(1'b0, 7'd42, 8'h3C);
    applyStimulus(1'b1, 7'd42, 8'h00);
    waitDrain();
    randomTraffic(150);
    waitDrain();

    // Reset during the clear sweep restarts it from address 0.
    applyStimulus(1'b0, 7'd80, 8'hAB);
    waitDrain();
    resetDut(0);
    randomTraffic(8);
    resetDut(0);
    measureBusy(MEM_WORDS);
    applyStimulus(1'b1, 7'd80, 8'h00);
    applyStimulus(1'b1, 7'd5, 8'h00);
    waitDrain();

    // Instance 1: strobe held active through reset, then preload.
    $display("[TB] instance 1: active-low, two wait states, no clear");
    cur = 1;
    latch_v[1] = 1'b0;
    resetDut(1);
    measureBusy(0);
    repeat (6) @(negedge clk);
    waitDrain();
    latch_v[1] = 1'b1;
    @(negedge clk);
    for (int a = 0; a < MEM_WORDS; a++) begin
      applyStimulus(1'b0, 7'(a), 8'($urandom));
      repeat (WS_B) @(negedge clk);
    end
    waitDrain();

    applyStimulus(1'b0, 7'd3, 8'h55);
    repeat (WS_B) @(negedge clk);
    applyStimulus(1'b1, 7'd3, 8'h00);
    waitDrain();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("dout_hold", 32'(dout_v[1]), 32'(last_read[1]));
    end

    // Second strobe while waiting must be dropped.
    applyStimulus(1'b1, 7'd3, 8'h00);
    applyStimulus(1'b0, 7'd3, 8'hEE);
    waitDrain();
    applyStimulus(1'b1, 7'd3, 8'h00);
    waitDrain();

    applyStimulus(1'b0, 7'd89, 8'hA3);
    repeat (WS_B) @(negedge clk);
    applyStimulus(1'b1, 7'd89, 8'h00);
    waitDrain();
    applyStimulus(1'b1, 7'd120, 8'h00);
    waitDrain();

    // Reset while a write is still waiting: the write must not land.
    applyStimulus(1'b0, 7'd10, 8'h11);
    waitDrain();
    saved = model_mem[1][10];
    applyStimulus(1'b0, 7'd10, 8'h77);
    resetDut(1);
    model_mem[1][10] = saved;
    measureBusy(0);
    applyStimulus(1'b1, 7'd10, 8'h00);
    applyStimulus(1'b1, 7'd10, 8'h00);
    waitDrain();

    randomTraffic(150);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clocked_bus_memory.md
Name: clocked_bus_memory

Overview:
Synchronous, parametrised successor of the team's strobe-driven memory block. A bus master requests an access with a latch strobe and an RW level; the block performs a read or write after a programmable number of wait states and acknowledges with a one-cycle ready pulse. It adds an optional sequential clear after reset, a busy flag and out-of-range address detection. It sits between the bus master logic and on-chip storage as a single-clock-domain slave.

Parameters:
DATA_SIZE, 8, data bus and memory word width in bits
ADDR_SIZE, 7, address bus width in bits
MEMORY_SIZE, 90, number of words; must be ≤ 2^ADDR_SIZE
POL_LATCH, 1, 1 = latch active-high; 0 = active-low (inverted internally)
POL_RW, 1, 1 = RW high means read; 0 = RW inverted internally
WAIT_STATES, 0, extra cycles between request accept and access; range 0..15
CLEAR_ON_RESET, 1, 1 = zero all words sequentially after reset; 0 = skip the clear

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
latch  input  1  request strobe; polarity set by POL_LATCH; sampled on clk
RW  input  1  access direction; polarity set by POL_RW; 1 (internal) = read
addIn  input  ADDR_SIZE  access address
DataBusIn  input  DATA_SIZE  write data
DataBusOut  output  DATA_SIZE  read data; registered
ready  output  1  one-cycle completion pulse
busy  output  1  high whenever state ≠ IDLE
err  output  1  one-cycle pulse, coincident with ready, when addIn ≥ MEMORY_SIZE

Behaviour:
- Internal signals: ilatch = latch XNOR POL_LATCH; iRW = RW XNOR POL_RW.
- Edge detector: latch_q <= ilatch each clk. A request is a clk edge with ilatch=1 and latch_q=0.
- Reset (asynchronous, rst_n low) forces:
  - DataBusOut=0, ready=0, err=0, latch_q=1 (a strobe held high through reset is not a request).
  - State = INIT if CLEAR_ON_RESET, otherwise IDLE; busy follows the state.
  - Wait counter and clear pointer = 0.
  - Memory contents are not reset asynchronously.
- FSM states: INIT, IDLE, WAIT, ACCESS.
  - INIT: writes 0 to address ptr, one word per cycle, ptr 0..MEMORY_SIZE-1. After writing MEMORY_SIZE-1, goes to IDLE. busy stays high for exactly MEMORY_SIZE cycles after reset release. Requests in INIT are ignored and lost.
  - IDLE: on a request edge, captures addIn, DataBusIn and iRW into holding registers. Goes to WAIT (counter loaded with WAIT_STATES-1) if WAIT_STATES>0, else to ACCESS.
  - WAIT: counter decrements each cycle; at 0 goes to ACCESS. Request edges are ignored.
  - ACCESS (one cycle):
    - In-range write: mem[addr] <= data.
    - In-range read: DataBusOut <= mem[addr].
    - Out of range: no write; a read loads DataBusOut <= 0; err <= 1.
    - ready <= 1; go to IDLE.
- ready and err are high for exactly one cycle. They clear on the next edge.
- Latency: with the request accepted at clk edge T, ready is high during the cycle after edge T+1+WAIT_STATES.
- DataBusOut holds its value until the next read completes; writes never change it.
- Back-to-back: a new request edge may be accepted on the edge right after the ACCESS edge (while ready is high). It is only recognised if latch returned inactive at some earlier sampled edge.
- Capture is at accept; changes to addIn, DataBusIn or RW after accept have no effect.
- Reset mid-operation:
  - Reset during WAIT: the access is abandoned, with no write and no ready.
  - Reset during INIT: the clear restarts from address 0.
- Write-then-read to the same address in consecutive requests returns the new data.

Test Plan:
1. CLEAR_ON_RESET=1, MEMORY_SIZE=90: release rst_n → busy high for exactly 90 cycles, then 0. A read of addr 5 returns 0x00 with ready pulse and err=0.
2. WAIT_STATES=2: write 0x55 to addr 3 (edge at T) → ready during the cycle after T+3. Then read addr 3 → DataBusOut=0x55 on the ready cycle and stays 0x55 for the following 10 idle cycles.
3. POL_LATCH=0, POL_RW=0: falling latch with RW=0 reads; falling latch with RW=1 writes 0xA3 to addr 89. A rising latch produces no ready. A read of addr 89 returns 0xA3.
4. Read of addr 100 (≥ 90) → ready=1 and err=1 in the same cycle, DataBusOut=0x00. A write of 0xFF to addr 127 → err pulse; a subsequent read of addr 0 is unaffected.
5. WAIT_STATES=3: a second latch edge during WAIT is ignored, giving exactly one ready pulse. Latch held high through reset release → no request until latch drops and rises again.
6. Assert rst_n low during WAIT of a write 0x77 to addr 10 (CLEAR_ON_RESET=0, addr 10 preloaded with 0x11) → no ready pulse. A read of addr 10 after reset returns 0x11.
